// File: rtl/mem_bridge_pkg.sv
// Shared types and width helpers for the memory bridge and its posted-write buffer.
package mem_bridge_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2,
    RESP  = 2'd3
  } state_t;

  // Wait-state counter width; stays 1 bit wide when there are no wait states.
  function automatic int cnt_width(input int wait_states);
    return (wait_states < 1) ? 1 : $clog2(wait_states + 1);
  endfunction

  function automatic int ptr_width(input int depth);
    return (depth < 2) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/mem_wbuf_fifo.sv
// Posted-write FIFO of packed {addr, data}; the count disambiguates full from empty.
module mem_wbuf_fifo
  import mem_bridge_pkg::*;
#(
  parameter  int DEPTH = 4,
  parameter  int DW    = 24,
  localparam int PW    = ptr_width(DEPTH),
  localparam int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [DW-1:0] push_data,
  input  logic          pop,
  output logic [DW-1:0] head,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);

  localparam logic [CW-1:0] FULL_C = CW'(DEPTH);

  logic [DW-1:0] slots [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic          push_en, pop_en;

  assign full    = (count == FULL_C);
  assign empty   = (count == '0);
  assign push_en = push & ~full;
  assign pop_en  = pop & ~empty;
  assign head    = slots[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_en) wr_ptr <= wr_ptr + PW'(1);
      if (pop_en)  rd_ptr <= rd_ptr + PW'(1);
      case ({push_en, pop_en})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_en) slots[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/mem_bridge.sv
// Valid/ready front end to an internal word memory with wait-stated accesses,
// posted writes and a registered read response that also drives the main bus.
module mem_bridge
  import mem_bridge_pkg::*;
#(
  parameter  int WIDTH       = 8,
  parameter  int WIDTH_ADDR  = 16,
  parameter  int WAIT_STATES = 1,
  parameter  int WBUF_DEPTH  = 4,
  localparam int CW          = $clog2(WBUF_DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [WIDTH_ADDR-1:0] req_addr,
  input  logic [WIDTH-1:0]      req_wdata,
  output logic                  rsp_valid,
  output logic [WIDTH-1:0]      rsp_rdata,
  input  logic                  assert_main,
  output logic [WIDTH-1:0]      main_out,
  output logic                  main_en,
  output logic [CW-1:0]         wbuf_count,
  output logic                  busy
);

  localparam int               CNT_W   = cnt_width(WAIT_STATES);
  localparam logic [CNT_W-1:0] WS_C    = CNT_W'(WAIT_STATES);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam bit               NO_WAIT = (WAIT_STATES == 0);

  state_t                  state;
  logic [CNT_W-1:0]        cnt;
  logic [WIDTH_ADDR-1:0]   acc_addr;
  logic [WIDTH-1:0]        acc_data;
  logic                    rd_loaded;

  // Word 0 must read as all-ones before any write; the rest are don't-care.
  logic [WIDTH-1:0] mem [2**WIDTH_ADDR] = '{default: {WIDTH{1'b1}}};

  logic                        wbuf_full, wbuf_empty;
  logic                        push, pop, rd_fire, mem_we;
  logic [WIDTH_ADDR+WIDTH-1:0] head;
  logic [WIDTH_ADDR-1:0]       head_addr, mem_waddr, rd_addr;
  logic [WIDTH-1:0]            head_data, mem_wdata, rd_word;

  assign {head_addr, head_data} = head;

  // Reads wait for an idle engine and an empty buffer so they see every earlier write.
  assign req_ready = req_write ? (~wbuf_full && state != READ && state != RESP)
                               : (state == IDLE && wbuf_empty);
  assign push    = req_valid & req_write & req_ready;
  assign rd_fire = req_valid & ~req_write & req_ready;
  assign pop     = (state == IDLE) & ~wbuf_empty;

  mem_wbuf_fifo #(
    .DEPTH (WBUF_DEPTH),
    .DW    (WIDTH_ADDR + WIDTH)
  ) u_wbuf (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data ({req_addr, req_wdata}),
    .pop       (pop),
    .head      (head),
    .count     (wbuf_count),
    .full      (wbuf_full),
    .empty     (wbuf_empty)
  );

  // With no wait states the pop/accept cycle is also the commit/sample cycle.
  assign mem_we    = NO_WAIT ? pop : (state == WRITE && cnt == WS_C);
  assign mem_waddr = NO_WAIT ? head_addr : acc_addr;
  assign mem_wdata = NO_WAIT ? head_data : acc_data;
  assign rd_addr   = NO_WAIT ? req_addr  : acc_addr;
  assign rd_word   = mem[rd_addr];

  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      acc_addr  <= '0;
      acc_data  <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rd_loaded <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (pop) begin
            acc_addr <= head_addr;
            acc_data <= head_data;
            cnt      <= CNT_ONE;
            if (!NO_WAIT) state <= WRITE;
          end else if (rd_fire) begin
            acc_addr <= req_addr;
            cnt      <= CNT_ONE;
            if (NO_WAIT) begin
              rsp_rdata <= rd_word;
              rsp_valid <= 1'b1;
              state     <= RESP;
            end else begin
              state <= READ;
            end
          end
        end
        WRITE: begin
          if (cnt < WS_C) cnt   <= cnt + CNT_ONE;
          else            state <= IDLE;
        end
        READ: begin
          if (cnt < WS_C) begin
            cnt <= cnt + CNT_ONE;
          end else begin
            rsp_rdata <= rd_word;
            rsp_valid <= 1'b1;
            state     <= RESP;
          end
        end
        RESP: begin
          rd_loaded <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign main_out = rsp_rdata;
  assign main_en  = ~assert_main & rd_loaded;
  assign busy     = (state != IDLE) || (wbuf_count != '0);

endmodule

// File: tb/tb_mem_bridge.sv
// Scoreboard bench: stimulus pushes expected read responses, a negedge monitor pops and compares.
module tb_mem_bridge;

  localparam int WS    = 3;
  localparam int DEPTH = 4;
  localparam int W     = 8;
  localparam int AW    = 16;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          req_valid = 1'b0, req_write = 1'b0, assert_main = 1'b1;
  logic [AW-1:0] req_addr = '0;
  logic [W-1:0]  req_wdata = '0;
  logic          req_ready, rsp_valid, main_en, busy;
  logic [W-1:0]  rsp_rdata, main_out;
  logic [CW-1:0] wbuf_count;

  logic          z_req_valid = 1'b0, z_req_write = 1'b0, z_assert_main = 1'b0;
  logic [AW-1:0] z_req_addr = '0;
  logic [W-1:0]  z_req_wdata = '0;
  logic          z_req_ready, z_rsp_valid, z_main_en, z_busy;
  logic [W-1:0]  z_rsp_rdata, z_main_out;
  logic [CW-1:0] z_wbuf_count;

  mem_bridge #(.WIDTH(W), .WIDTH_ADDR(AW), .WAIT_STATES(WS), .WBUF_DEPTH(DEPTH)) u_dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .assert_main(assert_main),
    .main_out(main_out), .main_en(main_en), .wbuf_count(wbuf_count), .busy(busy)
  );

  mem_bridge #(.WIDTH(W), .WIDTH_ADDR(AW), .WAIT_STATES(0), .WBUF_DEPTH(DEPTH)) u_z (
    .clk(clk), .rst_n(rst_n), .req_valid(z_req_valid), .req_ready(z_req_ready),
    .req_write(z_req_write), .req_addr(z_req_addr), .req_wdata(z_req_wdata),
    .rsp_valid(z_rsp_valid), .rsp_rdata(z_rsp_rdata), .assert_main(z_assert_main),
    .main_out(z_main_out), .main_en(z_main_en), .wbuf_count(z_wbuf_count), .busy(z_busy)
  );

  typedef struct {
    logic [W-1:0] data;
    int           due;
  } exp_t;

  int            checks = 0, failures = 0, cyc = 0;
  exp_t          sb[$];
  logic [W-1:0]  model [logic [AW-1:0]];
  logic [AW-1:0] known[$];
  bit            rd_seen = 1'b0;
  int            rd_cyc = 0;
  logic [W-1:0]  last_data = '0;
  int            exp_off [6] = '{0, 1, 2, 3, 4, 6};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial forever begin
    @(posedge clk);
    #2 assert_main = 1'($urandom_range(0, 1));
  end

  // Monitor: protocol rules, response ordering/latency, held data and the bus drive.
  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      sb.delete();
      rd_seen   = 1'b0;
      last_data = '0;
    end else begin
      if (req_valid && req_ready) begin
        if (!req_write) chk("rd_ready_rule", 32'(sb.size() == 0 && wbuf_count == 0), 1);
        else            chk("wr_ready_rule", 32'(sb.size() == 0 && wbuf_count < DEPTH), 1);
      end
      if (rsp_valid) begin
        if (sb.size() == 0) begin
          chk("rsp_unexpected", 1, 0);
          last_data = rsp_rdata;
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("rsp_data", 32'(rsp_rdata), 32'(e.data));
          chk("rsp_cycle", cyc, e.due);
          last_data = e.data;
        end
        if (!rd_seen) begin
          rd_seen = 1'b1;
          rd_cyc  = cyc;
        end
      end else if (sb.size() != 0 && sb[0].due < cyc) begin
        chk("rsp_missing", 0, 1);
        void'(sb.pop_front());
      end
      chk("rdata_hold", 32'(rsp_rdata), 32'(last_data));
      chk("main_out", 32'(main_out), 32'(rsp_rdata));
      chk("main_en", 32'(main_en), 32'(!assert_main && rd_seen && cyc > rd_cyc));
    end
  end

  task automatic do_req(input bit wr, input logic [AW-1:0] a, input logic [W-1:0] d,
                        input bit apply, output int acc);
    req_valid = 1'b1; req_write = wr; req_addr = a; req_wdata = d;
    acc = -1;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (req_ready) begin
        acc = cyc;
        break;
      end
    end
    @(posedge clk);
    #1 req_valid = 1'b0;
    if (acc < 0) begin
      chk("req_timeout", 0, 1);
    end else if (wr) begin
      if (apply) begin
        if (!model.exists(a)) known.push_back(a);
        model[a] = d;
      end
    end else begin
      exp_t e;
      e.data = model[a];
      e.due  = acc + WS + 1;
      sb.push_back(e);
    end
  endtask

  task automatic wait_idle(output int c);
    c = -1;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if (!busy && sb.size() == 0) begin
        c = cyc;
        break;
      end
    end
    if (c < 0) chk("idle_timeout", 0, 1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int w, r, c, dummy, zw, zr;
    int acc [6];
    logic [AW-1:0] a;

    model[16'h0000] = 8'hFF;
    known.push_back(16'h0000);

    repeat (3) @(negedge clk);
    chk("rst_rsp_valid", 32'(rsp_valid), 0);
    chk("rst_rsp_rdata", 32'(rsp_rdata), 0);
    chk("rst_main_en", 32'(main_en), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_wbuf_count", 32'(wbuf_count), 0);
    chk("rst_req_ready", 32'(req_ready), 1);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Power-on read of word 0, then write followed by a dependent read.
    do_req(1'b0, 16'h0000, '0, 1'b1, r);
    do_req(1'b1, 16'h1234, 8'hA5, 1'b1, w);
    chk("wr_count_one", 32'(wbuf_count), 1);
    do_req(1'b0, 16'h1234, '0, 1'b1, r);
    chk("rd_after_wr_cycle", r - w, WS + 2);
    chk("wr_count_drained", 32'(wbuf_count), 0);
    wait_idle(c);

    // Back-to-back writes fill the buffer and stall one.
    for (int k = 0; k < 6; k++) begin
      do_req(1'b1, AW'(16'h0100 + k), W'($urandom), 1'b1, acc[k]);
      if (k == 4) begin
        chk("b2b_count_full", 32'(wbuf_count), DEPTH);
        chk("b2b_ready_full", 32'(req_ready), 0);
      end
    end
    for (int k = 0; k < 6; k++) chk($sformatf("b2b_accept%0d", k), acc[k] - acc[0], exp_off[k]);
    wait_idle(c);
    chk("b2b_busy_drop", c - acc[0], 25);
    for (int k = 0; k < 6; k++) do_req(1'b0, AW'(16'h0100 + k), '0, 1'b1, dummy);
    wait_idle(c);

    // Three full laps of the buffer pointers.
    for (int k = 0; k < 3 * DEPTH; k++) do_req(1'b1, AW'(16'h2000 + 7 * k), W'($urandom), 1'b1, dummy);
    for (int k = 0; k < 3 * DEPTH; k++) do_req(1'b0, AW'(16'h2000 + 7 * k), '0, 1'b1, dummy);
    wait_idle(c);

    // Reset in the middle of a write with two more buffered: none may land.
    for (int k = 0; k < 3; k++) do_req(1'b1, AW'(16'h0100 + k), ~model[AW'(16'h0100 + k)], 1'b0, dummy);
    chk("prerst_count", 32'(wbuf_count), 2);
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", 32'(busy), 0);
    chk("midrst_count", 32'(wbuf_count), 0);
    chk("midrst_rsp_valid", 32'(rsp_valid), 0);
    chk("midrst_rsp_rdata", 32'(rsp_rdata), 0);
    chk("midrst_main_en", 32'(main_en), 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) do_req(1'b0, AW'(16'h0100 + k), '0, 1'b1, dummy);
    wait_idle(c);

    // Random mix against the reference memory.
    for (int i = 0; i < 120; i++) begin
      if ($urandom_range(0, 99) < 55) begin
        a = AW'(16'h4000 + $urandom_range(0, 15));
        do_req(1'b1, a, W'($urandom), 1'b1, dummy);
      end else begin
        a = known[$urandom_range(0, known.size() - 1)];
        do_req(1'b0, a, '0, 1'b1, dummy);
      end
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end
    wait_idle(c);
    chk("end_count", 32'(wbuf_count), 0);

    // Zero-wait-state instance: single-cycle write then dependent read.
    z_req_valid = 1'b1; z_req_write = 1'b1; z_req_addr = 16'h0010; z_req_wdata = 8'h3C;
    zw = -1;
    for (int i = 0; i < 20 && zw < 0; i++) begin
      @(negedge clk);
      if (z_req_ready) zw = cyc;
    end
    @(posedge clk);
    #1 z_req_write = 1'b0;
    zr = -1;
    for (int i = 0; i < 20 && zr < 0; i++) begin
      @(negedge clk);
      if (z_req_ready) zr = cyc;
    end
    @(posedge clk);
    #1 z_req_valid = 1'b0;
    chk("z_wr_accepted", 32'(zw >= 0), 1);
    chk("z_rd_accept_cycle", zr - zw, 2);
    @(negedge clk);
    chk("z_rsp_valid", 32'(z_rsp_valid), 1);
    chk("z_rsp_rdata", 32'(z_rsp_rdata), 32'h3C);
    chk("z_main_en_early", 32'(z_main_en), 0);
    @(negedge clk);
    chk("z_rsp_pulse", 32'(z_rsp_valid), 0);
    chk("z_main_en", 32'(z_main_en), 1);
    chk("z_main_out", 32'(z_main_out), 32'h3C);
    chk("z_busy", 32'(z_busy), 0);
    chk("z_count", 32'(z_wbuf_count), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_bridge.md
Name: mem_bridge

Overview:
Parametrised successor to the single-cycle main-bus/memory block. It owns a 2**WIDTH_ADDR-word internal memory and serves it over a valid/ready request port with a registered read-response port. Memory accesses take a configurable number of wait states, and writes are posted into a FIFO write buffer. The main-bus drive path (main_out/main_en) is kept, so it drops into the same bus fabric.

Parameters:
WIDTH, 8, data word width
WIDTH_ADDR, 16, address width; memory depth 2**WIDTH_ADDR
WAIT_STATES, 1, extra cycles per memory access (0 allowed; access = WAIT_STATES+1 cycles)
WBUF_DEPTH, 4, posted-write buffer entries (power of 2, >=2)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  reset, asynchronous, active-low
req_valid  in  1  request present
req_ready  out  1  request accepted when valid&ready at the clock edge
req_write  in  1  1=write, 0=read
req_addr  in  WIDTH_ADDR  address
req_wdata  in  WIDTH  write data
rsp_valid  out  1  one-cycle read-data-valid pulse
rsp_rdata  out  WIDTH  last read data, held until the next read response
assert_main  in  1  active-low: 0 = request to drive the main bus
main_out  out  WIDTH  equals rsp_rdata
main_en  out  1  !assert_main & rd_loaded (rd_loaded = at least one read completed since reset)
wbuf_count  out  $clog2(WBUF_DEPTH)+1  buffered writes not yet started
busy  out  1  engine not IDLE or wbuf_count!=0

Behaviour:
- Reset (async assert, sync release): FSM=IDLE, buffer empty, wbuf_count=0, rsp_valid=0, rsp_rdata=0, rd_loaded=0, so main_en=0 and busy=0. Memory contents are not reset. The simulation initial value of word 0 is all-ones; other words are undefined.
- Engine FSM states:
  - IDLE -> WRITE: buffer non-empty; the head is popped in that same cycle.
  - IDLE -> READ: a read is accepted.
  - WRITE -> WRITE or READ -> READ: while the cycle counter < WAIT_STATES.
  - Last cycle of WRITE -> IDLE.
  - Last cycle of READ -> RESP.
  - RESP -> IDLE after one cycle.
- Access timing: an access occupies WAIT_STATES+1 cycles, counting the pop/accept cycle. A write commits to memory on the last cycle's edge. A read samples memory into rsp_rdata on the last cycle's edge.
- Back-to-back writes: the engine completes WRITE and may pop the next entry in the immediately following cycle. No dead cycle between buffered writes.
- Write acceptance: req_ready = (wbuf_count < WBUF_DEPTH), evaluated on the registered count. Writes are accepted in any engine state except READ/RESP.
- Read acceptance: req_ready = engine IDLE & wbuf_count==0, so reads always observe all earlier writes. req_ready=0 for all requests during READ/RESP.
- req_ready depends on req_write (combinational).
- Read latency: accepted in cycle r -> rsp_valid high in cycle r+WAIT_STATES+1 for exactly one cycle.
- Push and pop in the same cycle: the count is unchanged. When full, no push happens, even if a pop occurs that cycle.
- FIFO pointers wrap modulo WBUF_DEPTH. The count distinguishes full from empty.
- Reset mid-operation: an in-flight write is not committed unless its last edge has passed. Buffered writes are discarded. A pending read response is dropped.
- WAIT_STATES=0: every access is single-cycle; the counter logic degenerates without a zero-width signal.

Decomposition:
- Package mem_bridge_pkg holds:
  - the FSM state encoding (IDLE, WRITE, READ, RESP);
  - helper localparams for the counter width max(1, $clog2(WAIT_STATES+1)) and the pointer width.
- One sub-module, mem_wbuf_fifo: parametrised WBUF_DEPTH FIFO of {addr, data} with push/pop/count/full/empty. It resets with the same async active-low reset.

Test Plan:
- WAIT_STATES=1: release reset, read addr 0x0000 accepted in cycle 0 -> rsp_valid only in cycle 2, rsp_rdata=0xFF. main_en=1 from cycle 3 while assert_main=0, and 0 when assert_main=1.
- Write 0x1234<=0xA5 in cycle 0, then present read 0x1234 in cycle 1 -> read not ready until the buffer drains and the engine is idle. Response is 0xA5; wbuf_count goes 1->0.
- WAIT_STATES=3, writes A..F presented back-to-back from cycle 0:
  - A pops in cycle 1; B–E buffered, wbuf_count=4 at the end of cycle 4.
  - req_ready=0 in cycle 5; F accepted in cycle 6.
  - Commits at the end of cycles 4, 8, 12, 16, 20, 24; busy drops in cycle 25.
- Pointer wrap: 3 rounds of WBUF_DEPTH writes to distinct addresses, then read each address -> all data correct, no loss or duplication.
- Reset asserted in cycle 2 of a 4-cycle write (WAIT_STATES=3) with 2 entries buffered -> outputs go to reset values immediately. Subsequent reads show none of the 3 writes committed.
- WAIT_STATES=0: write 0x0010<=0x3C then read 0x0010 -> write commits in its pop cycle, read is accepted the next cycle, and rsp_valid is high one cycle later with 0x3C.
